// File: rtl/reg32b_bist_if.sv
// Register-file bus between the BIST initiator (master) and the reg32b array (slave).
interface reg32b_bist_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_d_in;
  logic              rf_we_;
  logic [DATA_W-1:0] rf_d_out;

  modport master (output rf_addr, output rf_d_in, output rf_we_, input rf_d_out);
  modport slave  (input rf_addr, input rf_d_in, input rf_we_, output rf_d_out);
endinterface

// File: rtl/reg32b_bist.sv
// Self-test initiator for reg32b: writes a pattern to every entry, reads each back
// over two cycles (address, then compare) and reports pass, error count and first bad address.
module reg32b_bist #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  reg32b_bist_if.master     rf
);
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] ERR_MAX  = {IDX_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_CMP  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [IDX_W-1:0]  err_cnt_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_d_in_q;
  logic              rf_we_n_q;

  logic [IDX_W-1:0]  idx_inc_s;
  logic [IDX_W-1:0]  err_cnt_d;
  logic              mismatch_s;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        md,
                                                input logic [DATA_W-1:0] sd,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] a_ext;
    logic [DATA_W-1:0] alt;
    a_ext = DATA_W'(a);
    for (int i = 0; i < DATA_W; i++) begin
      alt[i] = ((i % 2) == 0) ? ~a[0] : a[0];
    end
    case (md)
      2'd0:    pattern = a_ext;
      2'd1:    pattern = ~a_ext;
      2'd2:    pattern = alt;
      2'd3:    pattern = sd ^ a_ext;
      default: pattern = a_ext;
    endcase
  endfunction

  // Read-back comparison and saturating error-count next state.
  always_comb begin
    idx_inc_s  = idx_q + IDX_W'(1);
    mismatch_s = (rf.rf_d_out != pattern(mode_q, seed_q, idx_q[ADDR_W-1:0]));
    if ((state_q == S_RD_CMP) && mismatch_s && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + IDX_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Test sequencer; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mode_q      <= 2'd0;
      seed_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      rf_addr_q   <= '0;
      rf_d_in_q   <= '0;
      rf_we_n_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q    <= 1'b0;
          rf_we_n_q <= 1'b1;
          rf_addr_q <= '0;
          rf_d_in_q <= '0;
          if (start) begin
            mode_q      <= mode;
            seed_q      <= seed;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            idx_q       <= '0;
            rf_we_n_q   <= 1'b0;
            rf_d_in_q   <= pattern(mode, seed, ADDR_W'(0));
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (idx_q == LAST_IDX) begin
            idx_q     <= '0;
            rf_we_n_q <= 1'b1;
            rf_addr_q <= '0;
            rf_d_in_q <= '0;
            state_q   <= S_RD_ADDR;
          end else begin
            idx_q     <= idx_inc_s;
            rf_addr_q <= idx_inc_s[ADDR_W-1:0];
            rf_d_in_q <= pattern(mode_q, seed_q, idx_inc_s[ADDR_W-1:0]);
          end
        end
        S_RD_ADDR: begin
          state_q <= S_RD_CMP;
        end
        S_RD_CMP: begin
          err_cnt_q <= err_cnt_d;
          if (mismatch_s && (err_cnt_q == '0)) begin
            fail_addr_q <= idx_q[ADDR_W-1:0];
          end
          if (idx_q == LAST_IDX) begin
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            pass_q    <= (err_cnt_d == '0);
            rf_addr_q <= '0;
            state_q   <= S_DONE;
          end else begin
            idx_q     <= idx_inc_s;
            rf_addr_q <= idx_inc_s[ADDR_W-1:0];
            state_q   <= S_RD_ADDR;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          rf_we_n_q <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign fail_addr  = fail_addr_q;
  assign rf.rf_addr = rf_addr_q;
  assign rf.rf_d_in = rf_d_in_q;
  assign rf.rf_we_  = rf_we_n_q;
endmodule

// File: tb/tb_reg32b_bist.sv
// Bench for reg32b_bist: behavioural register file with injectable faults, a cycle-indexed
// reference model of the expected bus activity and results, and directed plus random runs.
module tb_reg32b_bist;
  localparam int D = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic        busy;
  logic        done;
  logic        pass;
  logic [5:0]  err_cnt;
  logic [4:0]  fail_addr;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int fault;

  reg32b_bist_if #(.ADDR_W(5), .DATA_W(32)) rf_bus ();

  reg32b_bist #(.ADDR_W(5), .DATA_W(32), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .rf        (rf_bus)
  );

  always #5 clk = ~clk;

  // Behavioural reg32b: synchronous active-low write, combinational read, optional faults.
  logic [31:0] mem [D];
  logic [31:0] rd;
  always @(posedge clk) begin
    if (rf_bus.rf_we_ == 1'b0) mem[rf_bus.rf_addr] <= rf_bus.rf_d_in;
  end
  always_comb begin
    rd = mem[rf_bus.rf_addr];
    if (fault == 2) rd = 32'h0;
    else if (fault == 1 && (rf_bus.rf_addr == 5'd7 || rf_bus.rf_addr == 5'd20)) rd[0] = ~rd[0];
  end
  assign rf_bus.rf_d_out = rd;

  function automatic logic [31:0] pat(input int md, input logic [31:0] sd, input int a);
    case (md)
      0:       return 32'(a);
      1:       return 32'hFFFF_FFFF - 32'(a);
      2:       return ((a % 2) == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
      default: return sd ^ 32'(a);
    endcase
  endfunction

  function automatic bit bad(input int md, input logic [31:0] sd, input int a, input int flt);
    if (flt == 2) return pat(md, sd, a) != 32'h0;
    if (flt == 1) return (a == 7) || (a == 20);
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_c is the cycle number within the current/last run (1 = first write cycle).
  bit          m_active;
  int          m_c;
  int          m_mode;
  logic [31:0] m_seed;
  int          m_fault;
  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_c      <= 0;
    end else if (m_active) begin
      if (m_c == 3*D+1) m_active <= 1'b0;
      else m_c <= m_c + 1;
    end else if (start) begin
      m_active <= 1'b1;
      m_c      <= 1;
      m_mode   <= int'(mode);
      m_seed   <= seed;
      m_fault  <= fault;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin : cmp
    int e_err, e_fail, e_addr;
    logic e_we, e_busy, e_done, e_pass;
    logic [31:0] e_din;
    if (chk_en) begin
      e_err = 0; e_fail = 0;
      for (int a = 0; a < D; a++) begin
        if (bad(m_mode, m_seed, a, m_fault) && (D + 3 + 2*a <= m_c)) begin
          if (e_err == 0) e_fail = a;
          if (e_err < 63) e_err++;
        end
      end
      e_pass = (m_c == 3*D+1) && (e_err == 0);
      e_busy = m_active && (m_c <= 3*D);
      e_done = m_active && (m_c == 3*D+1);
      if (m_active && m_c <= D) begin
        e_we = 1'b0; e_addr = m_c - 1; e_din = pat(m_mode, m_seed, m_c - 1);
      end else if (m_active && m_c <= 3*D) begin
        e_we = 1'b1; e_addr = (m_c - D - 1) / 2; e_din = 32'h0;
      end else begin
        e_we = 1'b1; e_addr = 0; e_din = 32'h0;
      end
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("pass", 32'(pass), 32'(e_pass));
      chk("err_cnt", 32'(err_cnt), 32'(e_err));
      chk("fail_addr", 32'(fail_addr), 32'(e_fail));
      chk("rf_we_", 32'(rf_bus.rf_we_), 32'(e_we));
      chk("rf_addr", 32'(rf_bus.rf_addr), 32'(e_addr));
      chk("rf_d_in", rf_bus.rf_d_in, e_din);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run: start at edge 0, extra start pulses sampled at edges xa/xb, 110 cycles observed.
  task automatic run(input logic [1:0] md, input logic [31:0] sd, input int flt,
                     input int xa, input int xb, output int done_cyc, output int n_done);
    fault = flt;
    mode  = md;
    seed  = sd;
    start = 1'b1;
    tick();
    start    = 1'b0;
    mode     = 2'($urandom);
    seed     = $urandom;
    done_cyc = -1;
    n_done   = 0;
    for (int c = 1; c <= 110; c++) begin
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == xa || c == xb) start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  initial begin : stim
    int dc, nd;
    reset = 1'b1; start = 1'b0; mode = 2'd0; seed = 32'h0; fault = 0;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("reset_rf_we_", 32'(rf_bus.rf_we_), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    run(2'd0, 32'h0, 0, 0, 0, dc, nd);
    chk("m0_done_cycle", 32'(dc), 32'd97);
    chk("m0_pass", 32'(pass), 32'd1);
    chk("m0_err_cnt", 32'(err_cnt), 32'd0);
    chk("m0_fail_addr", 32'(fail_addr), 32'd0);
    chk("m0_mem31", mem[31], 32'd31);

    run(2'd3, 32'hDEAD_BEEF, 0, 0, 0, dc, nd);
    chk("m3_mem5", mem[5], 32'hDEAD_BEEA);
    chk("m3_pass", 32'(pass), 32'd1);

    run(2'd2, 32'h0, 0, 0, 0, dc, nd);
    chk("m2_mem0", mem[0], 32'h5555_5555);
    chk("m2_mem1", mem[1], 32'hAAAA_AAAA);
    chk("m2_pass", 32'(pass), 32'd1);

    run(2'd1, 32'h0, 1, 0, 0, dc, nd);
    chk("m1_flip_err_cnt", 32'(err_cnt), 32'd2);
    chk("m1_flip_fail_addr", 32'(fail_addr), 32'd7);
    chk("m1_flip_pass", 32'(pass), 32'd0);
    chk("m1_flip_done_cycle", 32'(dc), 32'd97);

    run(2'd0, 32'h0, 0, 10, 97, dc, nd);
    chk("restart_done_count", 32'(nd), 32'd1);
    chk("restart_done_cycle", 32'(dc), 32'd97);

    fault = 0; mode = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_rf_we_", 32'(rf_bus.rf_we_), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pass", 32'(pass), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    nd = 0;
    repeat (110) begin
      if (done) nd++;
      tick();
    end
    chk("midrst_no_done", 32'(nd), 32'd0);
    run(2'd0, 32'h0, 0, 0, 0, dc, nd);
    chk("after_rst_pass", 32'(pass), 32'd1);
    chk("after_rst_done_cycle", 32'(dc), 32'd97);

    run(2'd0, 32'h0, 2, 0, 0, dc, nd);
    chk("stuck0_err_cnt", 32'(err_cnt), 32'd31);
    chk("stuck0_fail_addr", 32'(fail_addr), 32'd1);
    chk("stuck0_pass", 32'(pass), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run(2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)),
          int'($urandom_range(2, 97)), int'($urandom_range(2, 97)), dc, nd);
      chk("rand_done_cycle", 32'(dc), 32'd97);
      chk("rand_done_count", 32'(nd), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg32b_bist.md
Name: reg32b_bist

Overview:
Hardware initiator for the 32-entry reg32b register file: drives its address, write-data and active-low write-enable pins, then reads back and compares. On a start pulse it writes a selected pattern to every entry, reads every entry back and reports pass/fail, the error count and the first failing address. It sits between the register file and the control/debug logic. It replaces bench-driven read/write checks with a synthesizable self-test.

Parameters:
ADDR_W, 5, register-file address width
DATA_W, 32, register-file data width
DEPTH, 32, number of entries tested (addresses 0..DEPTH-1, DEPTH <= 2**ADDR_W)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to run a test; ignored unless idle
mode  in  2  pattern select, sampled with start
seed  in  DATA_W  user pattern for mode 3, sampled with start
busy  out  1  test in progress
done  out  1  one-cycle pulse at test end
pass  out  1  result of last completed test
err_cnt  out  ADDR_W+1  mismatches in last/current test, saturating
fail_addr  out  ADDR_W  address of first mismatch
rf_addr  out  ADDR_W  to register file addr
rf_d_in  out  DATA_W  to register file d_in
rf_we_  out  1  to register file we_, active low
rf_d_out  in  DATA_W  from register file d_out

Behaviour:
- Reset (takes effect on the clk edge with reset=1): state IDLE; busy=0, done=0, pass=0, err_cnt=0, fail_addr=0, rf_addr=0, rf_d_in=0, rf_we_=1. The same applies mid-test: the write is aborted and rf_we_=1 from the next cycle on. No done pulse.
- Pattern p(a) for address a:
  - mode 0: a, zero-extended.
  - mode 1: bitwise ~a, zero-extended to DATA_W before inversion.
  - mode 2: 32'h5555_5555 if a[0]=0, else 32'hAAAA_AAAA (truncated or replicated to DATA_W).
  - mode 3: seed ^ a, with a zero-extended.
  - mode and seed are latched at start; later changes have no effect.
- FSM: IDLE -> WRITE -> RD_ADDR <-> RD_CMP -> DONE -> IDLE.
- IDLE:
  - rf_we_=1, rf_addr=0, rf_d_in=0.
  - On start=1: latch mode/seed, clear err_cnt and fail_addr, pass=0, busy=1, go to WRITE with index=0.
- WRITE:
  - One entry per cycle: rf_we_=0, rf_addr=index, rf_d_in=p(index).
  - After index DEPTH-1, go to RD_ADDR with index=0.
- RD_ADDR: rf_we_=1, rf_addr=index, rf_d_in=0. Go to RD_CMP.
- RD_CMP:
  - rf_addr is held at index and rf_d_out is sampled.
  - If rf_d_out != p(index): err_cnt increments, saturating at 2**(ADDR_W+1)-1. If err_cnt was 0, fail_addr<=index.
  - If index = DEPTH-1, go to DONE; else index+1 and go to RD_ADDR.
  - The two-cycle read supports both combinational and one-cycle-registered d_out.
- DONE:
  - done=1 for exactly one cycle; busy=0; pass=(err_cnt==0), including the final compare.
  - Return to IDLE. A start in the DONE cycle is ignored.
- Start while busy: ignored.
- Latency, DEPTH=32, start sampled at edge 0:
  - writes occupy cycles 1..32;
  - reads occupy cycles 33..96;
  - done=1 in cycle 97.
  - In general, done comes 3*DEPTH+1 cycles after start.
- Index counter is ADDR_W+1 bits wide so DEPTH = 2**ADDR_W does not wrap early.
- pass, err_cnt and fail_addr hold until the next start or reset.

Test Plan:
- Reset, then mode 0, start, against a correct reg32b -> rf_we_=0 with rf_d_in=a for a=0..31 in cycles 1..32; done=1 at cycle 97; pass=1, err_cnt=0, fail_addr=0.
- Mode 3, seed=32'hDEAD_BEEF -> entry 5 holds 32'hDEAD_BEEA; pass=1. Mode 2 -> entry 0 holds 32'h5555_5555 and entry 1 holds 32'hAAAA_AAAA; pass=1.
- Bench forces rf_d_out[0]=~rf_d_out[0] when rf_addr=7 and when rf_addr=20, mode 1 -> err_cnt=2, fail_addr=7, pass=0, done at cycle 97.
- start pulsed again at cycles 10 and 97 of a run -> neither restarts the test; busy stays high until cycle 97; exactly one done.
- reset asserted at cycle 15 (mid-write) -> next cycle: rf_we_=1, busy=0, pass=0, err_cnt=0, no done. A new start then completes normally with pass=1.
- Mode 0 with a stuck-at-0 model (rf_d_out=0) -> 31 mismatches, err_cnt=31, fail_addr=1, pass=0.
